// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply / divide unit: shift-add multiply and
// restoring divide, one bit per cycle, with a one-cycle completion pulse.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [1:0]       dbg_state
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;       // MUL: product; DIV: {remainder, dividend/quotient}
  logic [AW-1:0]    mcand_q, mcand_d;   // MUL: shifted multiplicand; DIV: divisor in low half
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic             last_iter;
  logic [AW-1:0]    addend, acc_mul, acc_div;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_n, quo, a_abs, b_abs;
  logic [WIDTH:0]   mul_top;
  logic             qbit;

  always_comb begin
    last_iter = (cnt_q == CW'(WIDTH - 1));
    // The multiplier's top bit carries negative weight in two's complement.
    addend    = last_iter ? (~mcand_q + AW'(1)) : mcand_q;
    acc_mul   = mplier_q[0] ? (acc_q + addend) : acc_q;
    mul_top   = acc_mul[AW-1:WIDTH-1];

    shifted   = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    trial     = shifted - {1'b0, mcand_q[WIDTH-1:0]};
    qbit      = ~trial[WIDTH];
    rem_n     = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    acc_div   = {rem_n, acc_q[WIDTH-2:0], qbit};
    quo       = acc_div[WIDTH-1:0];

    a_abs     = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    b_abs     = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (ctrl_MULT) begin
          state_d  = MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
          mplier_d = data_operandB;
        end else if (ctrl_DIV) begin
          state_d  = DIV;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, a_abs};
          mcand_d  = {{WIDTH{1'b0}}, b_abs};
          neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          dz_d     = (data_operandB == '0);
          ovf_d    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
        end
      end
      MUL: begin
        acc_d    = acc_mul;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          state_d  = DONE;
          rdy_d    = 1'b1;
          result_d = acc_mul[WIDTH-1:0];
          exc_d    = ~((&mul_top) | ~(|mul_top));
        end
      end
      DIV: begin
        acc_d = acc_div;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = DONE;
          rdy_d   = 1'b1;
          exc_d   = dz_q | ovf_q;
          if (dz_q)       result_d = '0;
          else if (ovf_q) result_d = {1'b1, {(WIDTH-1){1'b0}}};
          else            result_d = neg_q ? (~quo + WIDTH'(1)) : quo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: expected results queued at issue time,
// popped and compared by a monitor whenever the completion pulse appears.
module tb_multdiv_unit;
  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [1:0]  dbg_state;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .dbg_state(dbg_state)
  );

  // Clock / reset and edge counter
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rdy_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (data_resultRDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rdy", 64'(data_result), 64'hdead_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 64'(data_result), 64'(e.res));
        chk("exception", 64'(data_exception), 64'(e.exc));
        chk("rdy_cycle", 64'(cyc), 64'(e.rdy_cyc));
      end
    end
  end

  // Driver tasks (called right after a falling edge)
  task automatic start_op(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc);
    exp_t e;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mult;
    ctrl_DIV      = ~is_mult;
    e.res     = res;
    e.exc     = exc;
    e.rdy_cyc = cyc + 1 + 32;
    exp_q.push_back(e);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom_range(0, 32'hffff);
    data_operandB = $urandom_range(0, 32'hffff);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  typedef struct packed {
    logic        is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[10];
  int unsigned e0;

  initial begin
    vecs[0] = '{1'b1, 32'd7,          32'hffff_fffa, 32'hffff_ffd6, 1'b0};
    vecs[1] = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2] = '{1'b1, 32'hffff_ffff,  32'h8000_0000, 32'h8000_0000, 1'b1};
    vecs[3] = '{1'b1, 32'd12345,      32'd1000,      32'h00bc_5ea8, 1'b0};
    vecs[4] = '{1'b1, 32'hffff_fffd,  32'hffff_fffb, 32'd15,        1'b0};
    vecs[5] = '{1'b0, 32'hffff_fff9,  32'd2,         32'hffff_fffd, 1'b0};
    vecs[6] = '{1'b0, 32'd100,        32'hffff_fff9, 32'hffff_fff2, 1'b0};
    vecs[7] = '{1'b0, 32'hffff_ff9c,  32'hffff_fff9, 32'd14,        1'b0};
    vecs[8] = '{1'b0, 32'd5,          32'd0,         32'd0,         1'b1};
    vecs[9] = '{1'b0, 32'h8000_0000,  32'hffff_ffff, 32'h8000_0000, 1'b1};

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exc", 64'(data_exception), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].is_mult, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);
      wait_drain();
    end

    // Start requests during an operation are ignored; back-to-back start in DONE.
    start_op(1'b1, 32'd7, 32'hffff_fffa, 32'hffff_ffd6, 1'b0);
    e0 = cyc;
    repeat (9) @(negedge clock);
    chk("hold_result", 64'(data_result), 64'h8000_0000);
    chk("hold_exc", 64'(data_exception), 64'd1);
    chk("busy_state", 64'(dbg_state), 64'd1);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'hffff_fff9;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    while (cyc < e0 + 32) @(negedge clock);
    start_op(1'b0, 32'd100, 32'hffff_fff9, 32'hffff_fff2, 1'b0);
    wait_drain();

    // Reset in the middle of a divide abandons it.
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_result", 64'(data_result), 64'd0);
    chk("midreset_exc", 64'(data_exception), 64'd0);
    chk("midreset_rdy", 64'(data_resultRDY), 64'd0);
    chk("midreset_state", 64'(dbg_state), 64'd0);
    repeat (40) @(negedge clock);

    // Reset beats a simultaneous start.
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    reset = 1'b0;
    chk("reset_vs_start_state", 64'(dbg_state), 64'd0);
    repeat (40) @(negedge clock);
    chk("reset_vs_start_idle", 64'(dbg_state), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
